// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional backpressure counter on stall_cnt is enabled by defining MEM_WB_STALL_CNT_EN.
module mem_wb_skid_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [ADDR_W-1:0] reg_write_addr_in,
  input  logic              reg_write_en_in,
  input  logic              mem_to_reg_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [ADDR_W-1:0] reg_write_addr_out,
  output logic              reg_write_en_out,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PAY_W = 2*DATA_W + ADDR_W + 2;

  // Encoding keeps bit0 = main valid, bit1 = skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t           state;
  logic [PAY_W-1:0] main_q;
  logic [PAY_W-1:0] skid_q;
  logic [PAY_W-1:0] in_pay;
  logic             accept;
  logic             send;
  logic             head_en;
  logic             head_m2r;

  assign in_pay = {mem_data_in, alu_result_in, reg_write_addr_in,
                   reg_write_en_in, mem_to_reg_in};

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign send      = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_pay;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && send) begin
            main_q <= in_pay;
          end else if (accept) begin
            skid_q <= in_pay;
            state  <= FULL;
          end else if (send) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (send) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign {mem_data_out, alu_result_out, reg_write_addr_out, head_en, head_m2r} = main_q;

  // A bubble or flushed head must never produce a register-file write.
  assign reg_write_en_out = head_en & out_valid;
  assign wb_data          = head_m2r ? mem_data_out : alu_result_out;

`ifdef MEM_WB_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (out_valid && !out_ready && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Self-checking bench for mem_wb_skid_reg: directed plan steps plus random traffic,
// compared against a queue-based reference model.
module tb_mem_wb_skid_reg;

  typedef struct packed {
    logic [31:0] md;
    logic [31:0] alu;
    logic [4:0]  ad;
    logic        en;
    logic        m2r;
  } pay_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] mem_data_in;
  logic [31:0] alu_result_in;
  logic [4:0]  reg_write_addr_in;
  logic        reg_write_en_in;
  logic        mem_to_reg_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] mem_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  reg_write_addr_out;
  logic        reg_write_en_out;
  logic [31:0] wb_data;
  logic [3:0]  stall_cnt;

  int   checks;
  int   errors;
  pay_t q[$];
  int   cnt_m;

  mem_wb_skid_reg #(
    .DATA_W(32),
    .ADDR_W(5),
    .CNT_W (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .mem_data_in       (mem_data_in),
    .alu_result_in     (alu_result_in),
    .reg_write_addr_in (reg_write_addr_in),
    .reg_write_en_in   (reg_write_en_in),
    .mem_to_reg_in     (mem_to_reg_in),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .mem_data_out      (mem_data_out),
    .alu_result_out    (alu_result_out),
    .reg_write_addr_out(reg_write_addr_out),
    .reg_write_en_out  (reg_write_en_out),
    .wb_data           (wb_data),
    .stall_cnt         (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    pay_t h;
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      h = q[0];
      chk("mem_data_out", 64'(mem_data_out), 64'(h.md));
      chk("alu_result_out", 64'(alu_result_out), 64'(h.alu));
      chk("reg_write_addr_out", 64'(reg_write_addr_out), 64'(h.ad));
      chk("reg_write_en_out", 64'(reg_write_en_out), 64'(h.en));
      chk("wb_data", 64'(wb_data), 64'(h.m2r ? h.md : h.alu));
    end else begin
      chk("reg_write_en_out_idle", 64'(reg_write_en_out), 64'(0));
    end
    chk("stall_cnt", 64'(stall_cnt), 64'(cnt_m));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    chk({tag, "_wen"}, 64'(reg_write_en_out), 64'(0));
    chk({tag, "_mem"}, 64'(mem_data_out), 64'(0));
    chk({tag, "_alu"}, 64'(alu_result_out), 64'(0));
    chk({tag, "_addr"}, 64'(reg_write_addr_out), 64'(0));
    chk({tag, "_wb"}, 64'(wb_data), 64'(0));
    chk({tag, "_stall"}, 64'(stall_cnt), 64'(0));
  endtask

  // Drive one cycle of inputs, advance the reference model across the edge, then check.
  task automatic step(input logic iv, input logic [31:0] md, input logic [31:0] alu,
                      input logic [4:0] ad, input logic en, input logic m2r,
                      input logic ordy, input logic fl);
    logic acc;
    logic snd;
    pay_t p;
    in_valid          = iv;
    mem_data_in       = md;
    alu_result_in     = alu;
    reg_write_addr_in = ad;
    reg_write_en_in   = en;
    mem_to_reg_in     = m2r;
    out_ready         = ordy;
    flush             = fl;
    acc = iv && (q.size() < 2) && !fl;
    snd = (q.size() > 0) && ordy;
    p   = '{md: md, alu: alu, ad: ad, en: en, m2r: m2r};
    @(posedge clk);
`ifdef MEM_WB_STALL_CNT_EN
    if (fl) cnt_m = 0;
    else if ((q.size() > 0) && !ordy && (cnt_m < 15)) cnt_m = cnt_m + 1;
`endif
    if (fl) begin
      q.delete();
    end else begin
      if (snd) void'(q.pop_front());
      if (acc) q.push_back(p);
    end
    #1;
    check_model();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cnt_m  = 0;
    reset  = 1'b0;
    flush  = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mem_data_in = '0;
    alu_result_in = '0;
    reg_write_addr_in = '0;
    reg_write_en_in = 1'b0;
    mem_to_reg_in = 1'b0;

    #2;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single push, mem_to_reg=1 then mem_to_reg=0.
    step(1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd21, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("push_m2r1_wb", 64'(wb_data), 64'h00000000A5A5A5A5);
    chk("push_m2r1_addr", 64'(reg_write_addr_out), 64'd21);
    step(1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd21, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("push_m2r0_wb", 64'(wb_data), 64'h000000005A5A5A5A);
    idle(1'b1);

    // Backpressure: X then Y held, released in order.
    step(1'b1, 32'h0, 32'hFFFFFFFF, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 32'h00000001, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head_x", 64'(alu_result_out), 64'hFFFFFFFF);
    step(1'b1, 32'h0, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_x", 64'(alu_result_out), 64'hFFFFFFFF);
    idle(1'b1);
    chk("bp_then_y", 64'(alu_result_out), 64'd1);
    idle(1'b1);
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Streaming 8 back-to-back entries.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 32'h0, 32'(i), 5'(i), 1'b1, 1'b0, 1'b1, 1'b0);
      chk("stream_value", 64'(alu_result_out), 64'(i));
      chk("stream_in_ready", 64'(in_ready), 64'd1);
    end
    idle(1'b1);

    // Flush while FULL with an offered entry.
    step(1'b1, 32'h0, 32'h11111111, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 32'h22222222, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0, 32'h33333333, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_wen", 64'(reg_write_en_out), 64'd0);
    step(1'b1, 32'h0, 32'h44444444, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_flush_push", 64'(alu_result_out), 64'h44444444);

    // Stall counter: 20 cycles of backpressure with a valid head, then flush.
    for (int i = 0; i < 20; i++) idle(1'b0);
`ifdef MEM_WB_STALL_CNT_EN
    chk("stall_saturated", 64'(stall_cnt), 64'd15);
`else
    chk("stall_tied_zero", 64'(stall_cnt), 64'd0);
`endif
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("stall_after_flush", 64'(stall_cnt), 64'd0);

    // Asynchronous reset mid-traffic with two entries held.
    step(1'b1, 32'hCAFE0001, 32'h1, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hCAFE0002, 32'h2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    in_valid = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    #9;
    check_reset_outputs("rst_held");
    reset = 1'b1;
    q.delete();
    cnt_m = 0;
    step(1'b1, 32'hBEEF0000, 32'h77, 5'd30, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("first_after_reset", 64'(alu_result_out), 64'h77);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid_reg.md
Name: mem_wb_skid_reg

Overview:
- Parametrised MEM/WB pipeline register for the next core generation; sits between the memory stage and register-file writeback.
- Adds a valid/ready handshake backed by a 2-entry skid buffer, a synchronous flush, and a writeback data select.
- Every transfer is registered, with no combinational in-to-out path on data, and ordering is strictly preserved.

Parameters:
DATA_W, 32, width of mem_data, alu_result and wb_data
ADDR_W, 5, width of register write address
CNT_W, 16, width of backpressure counter (optional feature)

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous active-low reset; 0 = reset asserted
flush  input  1  synchronous flush; drops all held and incoming entries
in_valid  input  1  upstream entry present
in_ready  output  1  block can accept this cycle
mem_data_in  input  DATA_W  load data from memory stage
alu_result_in  input  DATA_W  ALU result
reg_write_addr_in  input  ADDR_W  destination register
reg_write_en_in  input  1  writeback enable
mem_to_reg_in  input  1  1 = write back mem data, 0 = ALU result
out_valid  output  1  head entry present
out_ready  input  1  writeback consumes the head entry
mem_data_out  output  DATA_W  head entry mem data
alu_result_out  output  DATA_W  head entry ALU result
reg_write_addr_out  output  ADDR_W  head entry destination
reg_write_en_out  output  1  head reg_write_en AND out_valid
wb_data  output  DATA_W  mem_to_reg ? mem_data_out : alu_result_out (combinational from head register)
stall_cnt  output  CNT_W  backpressure cycle count (optional feature)

Behaviour:
- Storage: main register (head, drives outputs) and skid register; each has a valid bit. Payload is {mem_data, alu_result, addr, en, mem_to_reg}.
- accept = in_valid & in_ready & !flush. send = out_valid & out_ready.
- in_ready = !skid_valid (registered, no dependency on out_ready). out_valid = main_valid.
- States (derived from the valid bits): EMPTY (none valid), ONE (main only), FULL (main+skid). Skid valid without main valid is illegal.
- EMPTY: accept -> ONE with main <= input.
- ONE: accept & send -> ONE with main <= input. Accept & !send -> FULL with skid <= input. Send & !accept -> EMPTY.
- FULL: in_ready=0. Send -> ONE with main <= skid. !send -> hold.
- Latency: accept in cycle N -> out_valid and data visible in cycle N+1 when EMPTY, or ONE with send.
- Throughput: 1 entry/cycle when out_ready is held 1.
- Payload in the main register must not change while out_valid & !out_ready.
- flush: takes priority over all other events. Next cycle main_valid=0 and skid_valid=0. An input offered in the flush cycle is dropped. A send in the flush cycle still counts as consumed downstream. Payload registers may keep stale values.
- reg_write_en_out is forced 0 whenever out_valid=0, so no write can occur from a bubble, stale entry or flushed entry.
- Reset asserted (reset=0): immediately, without a clock, all valid bits are 0, all payload registers are 0, and all outputs are 0 except in_ready=1. Inputs are ignored while reset is asserted.
- Reset mid-operation discards all held entries.
- Reset release is synchronous to clk; the first accept is possible on the first edge with reset=1.

Optional Feature:
- Macro: MEM_WB_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 on every clock where out_valid & !out_ready. It saturates at 2^CNT_W-1 and does not wrap. It resets to 0 on reset, and also when flush=1 (flush has priority over increment).
- Not defined: stall_cnt is tied to 0 and no counter logic is generated. The port is always present.

Test Plan:
- Reset pulse low for 10ns mid-traffic with 2 entries held -> out_valid=0, reg_write_en_out=0, in_ready=1, all data 0 immediately, without waiting for an edge.
- Push {mem=A5A5A5A5, alu=5A5A5A5A, addr=21, en=1, m2r=1} with out_ready=1 -> next cycle out_valid=1, wb_data=A5A5A5A5, addr_out=21, reg_write_en_out=1. With m2r=0, wb_data=5A5A5A5A.
- Backpressure: out_ready=0, push entries X (FFFFFFFF) then Y (00000001) -> in_ready=0 after Y (FULL). Head holds X. Release out_ready -> X then Y on consecutive cycles, in order, with no loss.
- Streaming of 8 back-to-back entries (alu=1..8) with out_ready=1 -> 8 consecutive out_valid cycles, values 1..8 in order, in_ready stays 1.
- flush while FULL with in_valid=1 -> next cycle out_valid=0 and reg_write_en_out=0. The flushed and offered entries never appear. A following push appears normally.
- With MEM_WB_STALL_CNT_EN defined, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated). Flush -> 0. Without the macro, stall_cnt stays 0 throughout.
